// File: rtl/aclk_pkg.sv
// Shared types and constants for the alarm-clock keypad entry controller.
package aclk_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t NOKEY = 4'd10;

  typedef enum logic [2:0] {
    SHOW_TIME  = 3'd0,
    SHOW_ALARM = 3'd1,
    ENTRY      = 3'd2,
    COMMIT_A   = 3'd3,
    COMMIT_C   = 3'd4,
    WAIT_REL   = 3'd5
  } state_t;

  // An HH:MM entry is legal when hours are 00..23 and minute tens are 0..5.
  function automatic logic time_valid(input digit_t ms_hr, input digit_t ls_hr,
                                      input digit_t ms_min);
    logic v_hr;
    v_hr = (ms_hr < 4'd2) || ((ms_hr == 4'd2) && (ls_hr <= 4'd3));
    return v_hr && (ms_min <= 4'd5);
  endfunction

endpackage

// File: rtl/aclk_timeout_cnt.sv
// Counts one_second ticks since the last key press; saturates at TIMEOUT_SEC.
module aclk_timeout_cnt #(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_expired
);

  localparam logic [3:0] LIMIT = 4'(TIMEOUT_SEC);

  logic [3:0] r_count;

  // Clear has priority so a press coinciding with a tick restarts the count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count <= 4'd0;
    end else if (i_clear) begin
      r_count <= 4'd0;
    end else if (i_tick && (r_count != LIMIT)) begin
      r_count <= r_count + 4'd1;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/aclk_key_entry.sv
// Keypad entry controller: collects HH:MM digits, commits them to the alarm or
// time counter, and abandons idle entries after a timeout.
module aclk_key_entry
  import aclk_pkg::*;
#(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic [3:0] key_ms_hr,
  output logic [3:0] key_ls_hr,
  output logic [3:0] key_ms_min,
  output logic [3:0] key_ls_min,
  output logic       show_new_time,
  output logic       show_a,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       key_error
);

  state_t r_state;
  state_t w_state_nxt;
  digit_t r_key_prev;
  digit_t r_ms_hr, r_ls_hr, r_ms_min, r_ls_min;
  digit_t w_ms_hr_nxt, w_ls_hr_nxt, w_ms_min_nxt, w_ls_min_nxt;
  logic   r_show_new_time, r_show_a, r_load_new_a, r_load_new_c, r_key_error;
  logic   w_show_new_time_nxt, w_show_a_nxt, w_load_new_a_nxt, w_load_new_c_nxt;
  logic   w_key_error_nxt;
  logic   w_press, w_valid, w_expired, w_cnt_clear;

  assign w_press     = (key <= 4'd9) && (r_key_prev == NOKEY);
  assign w_valid     = time_valid(r_ms_hr, r_ls_hr, r_ms_min);
  assign w_cnt_clear = (r_state != ENTRY) || w_press;

  aclk_timeout_cnt #(.TIMEOUT_SEC(TIMEOUT_SEC)) u_timeout (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (w_cnt_clear),
    .i_tick    (one_second),
    .o_expired (w_expired)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= SHOW_TIME;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, next digit values and next registered outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_ms_hr_nxt      = r_ms_hr;
    w_ls_hr_nxt      = r_ls_hr;
    w_ms_min_nxt     = r_ms_min;
    w_ls_min_nxt     = r_ls_min;
    w_load_new_a_nxt = 1'b0;
    w_load_new_c_nxt = 1'b0;
    w_key_error_nxt  = 1'b0;
    case (r_state)
      SHOW_TIME: begin
        if (alarm_button) begin
          w_state_nxt = SHOW_ALARM;
        end else if (w_press) begin
          w_state_nxt  = ENTRY;
          w_ms_hr_nxt  = 4'd0;
          w_ls_hr_nxt  = 4'd0;
          w_ms_min_nxt = 4'd0;
          w_ls_min_nxt = key;
        end else begin
          w_state_nxt = SHOW_TIME;
        end
      end
      SHOW_ALARM: begin
        if (!alarm_button) begin
          w_state_nxt = SHOW_TIME;
        end else begin
          w_state_nxt = SHOW_ALARM;
        end
      end
      ENTRY: begin
        if (alarm_button) begin
          w_state_nxt = COMMIT_A;
        end else if (time_button) begin
          w_state_nxt = COMMIT_C;
        end else if (w_press) begin
          w_ms_hr_nxt  = r_ls_hr;
          w_ls_hr_nxt  = r_ms_min;
          w_ms_min_nxt = r_ls_min;
          w_ls_min_nxt = key;
        end else if (w_expired) begin
          w_state_nxt  = SHOW_TIME;
          w_ms_hr_nxt  = 4'd0;
          w_ls_hr_nxt  = 4'd0;
          w_ms_min_nxt = 4'd0;
          w_ls_min_nxt = 4'd0;
        end else begin
          w_state_nxt = ENTRY;
        end
      end
      COMMIT_A: begin
        w_state_nxt      = WAIT_REL;
        w_load_new_a_nxt = w_valid;
        w_key_error_nxt  = !w_valid;
      end
      COMMIT_C: begin
        w_state_nxt      = WAIT_REL;
        w_load_new_c_nxt = w_valid;
        w_key_error_nxt  = !w_valid;
      end
      WAIT_REL: begin
        // Digits stay visible during the strobe, then clear here.
        w_ms_hr_nxt  = 4'd0;
        w_ls_hr_nxt  = 4'd0;
        w_ms_min_nxt = 4'd0;
        w_ls_min_nxt = 4'd0;
        if (!alarm_button && !time_button) begin
          w_state_nxt = SHOW_TIME;
        end else begin
          w_state_nxt = WAIT_REL;
        end
      end
      default: begin
        w_state_nxt  = SHOW_TIME;
        w_ms_hr_nxt  = 4'd0;
        w_ls_hr_nxt  = 4'd0;
        w_ms_min_nxt = 4'd0;
        w_ls_min_nxt = 4'd0;
      end
    endcase
    w_show_a_nxt        = (w_state_nxt == SHOW_ALARM);
    w_show_new_time_nxt = (w_state_nxt == ENTRY) || (w_state_nxt == COMMIT_A) ||
                          (w_state_nxt == COMMIT_C);
  end

  // Registered digits, key history and LCD/strobe outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_key_prev      <= NOKEY;
      r_ms_hr         <= 4'd0;
      r_ls_hr         <= 4'd0;
      r_ms_min        <= 4'd0;
      r_ls_min        <= 4'd0;
      r_show_new_time <= 1'b0;
      r_show_a        <= 1'b0;
      r_load_new_a    <= 1'b0;
      r_load_new_c    <= 1'b0;
      r_key_error     <= 1'b0;
    end else begin
      r_key_prev      <= key;
      r_ms_hr         <= w_ms_hr_nxt;
      r_ls_hr         <= w_ls_hr_nxt;
      r_ms_min        <= w_ms_min_nxt;
      r_ls_min        <= w_ls_min_nxt;
      r_show_new_time <= w_show_new_time_nxt;
      r_show_a        <= w_show_a_nxt;
      r_load_new_a    <= w_load_new_a_nxt;
      r_load_new_c    <= w_load_new_c_nxt;
      r_key_error     <= w_key_error_nxt;
    end
  end

  assign key_ms_hr     = r_ms_hr;
  assign key_ls_hr     = r_ls_hr;
  assign key_ms_min    = r_ms_min;
  assign key_ls_min    = r_ls_min;
  assign show_new_time = r_show_new_time;
  assign show_a        = r_show_a;
  assign load_new_a    = r_load_new_a;
  assign load_new_c    = r_load_new_c;
  assign key_error     = r_key_error;

endmodule

// File: tb/tb_aclk_key_entry.sv
// Scoreboard bench for aclk_key_entry: a behavioural model predicts every
// cycle's outputs into a queue that a posedge monitor drains and compares.
module tb_aclk_key_entry;

  localparam int TIMEOUT = 10;
  localparam int NK      = 10;

  localparam int M_IDLE   = 0;
  localparam int M_ALARM  = 1;
  localparam int M_EDIT   = 2;
  localparam int M_COMMIT = 3;
  localparam int M_HOLD   = 4;

  typedef struct packed {
    logic [3:0] ms_hr;
    logic [3:0] ls_hr;
    logic [3:0] ms_min;
    logic [3:0] ls_min;
    logic       snt;
    logic       sa;
    logic       la;
    logic       lc;
    logic       err;
  } out_t;

  logic       clock;
  logic       reset;
  logic       one_second;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;
  logic [3:0] key_ms_hr, key_ls_hr, key_ms_min, key_ls_min;
  logic       show_new_time, show_a, load_new_a, load_new_c, key_error;

  aclk_key_entry #(.TIMEOUT_SEC(TIMEOUT)) dut (
    .clock         (clock),
    .reset         (reset),
    .one_second    (one_second),
    .key           (key),
    .alarm_button  (alarm_button),
    .time_button   (time_button),
    .key_ms_hr     (key_ms_hr),
    .key_ls_hr     (key_ls_hr),
    .key_ms_min    (key_ms_min),
    .key_ls_min    (key_ls_min),
    .show_new_time (show_new_time),
    .show_a        (show_a),
    .load_new_a    (load_new_a),
    .load_new_c    (load_new_c),
    .key_error     (key_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  out_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Model: entered digits as a list (newest last), idle seconds, last key.
  int m_mode = M_IDLE;
  int m_digs[$];
  int m_idle = 0;
  int m_prev = NK;
  int m_kind = 0;

  function automatic int dig(input int pos);
    int idx;
    idx = m_digs.size() - 4 + pos;
    if (idx < 0) return 0;
    return m_digs[idx];
  endfunction

  task automatic step(input int k, input logic ab, input logic tb, input logic tk,
                      input logic rs);
    out_t e;
    bit   press;
    int   hh, mm;
    @(negedge clock);
    key = 4'(k); alarm_button = ab; time_button = tb; one_second = tk; reset = rs;
    e = '0;
    press = (k <= 9) && (m_prev == NK);
    if (!rs) begin
      m_mode = M_IDLE; m_digs.delete(); m_idle = 0; m_prev = NK;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (ab) m_mode = M_ALARM;
          else if (press) begin
            m_mode = M_EDIT; m_digs.delete(); m_digs.push_back(k); m_idle = 0;
          end
        end
        M_ALARM: if (!ab) m_mode = M_IDLE;
        M_EDIT: begin
          if (ab) begin m_mode = M_COMMIT; m_kind = 1; end
          else if (tb) begin m_mode = M_COMMIT; m_kind = 2; end
          else if (press) begin
            m_digs.push_back(k);
            if (m_digs.size() > 4) void'(m_digs.pop_front());
            m_idle = 0;
          end else if (m_idle == TIMEOUT) begin
            m_mode = M_IDLE; m_digs.delete();
          end else if (tk) m_idle++;
        end
        M_COMMIT: begin
          hh = 10 * dig(0) + dig(1);
          mm = 10 * dig(2) + dig(3);
          if (hh <= 23 && mm < 60) begin
            e.la = (m_kind == 1); e.lc = (m_kind == 2);
          end else e.err = 1'b1;
          m_mode = M_HOLD;
        end
        default: begin
          m_digs.delete();
          if (!ab && !tb) m_mode = M_IDLE;
        end
      endcase
      m_prev = k;
    end
    e.ms_hr = 4'(dig(0)); e.ls_hr = 4'(dig(1));
    e.ms_min = 4'(dig(2)); e.ls_min = 4'(dig(3));
    e.sa  = (m_mode == M_ALARM);
    e.snt = (m_mode == M_EDIT) || (m_mode == M_COMMIT);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(NK, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic tap(input int d);
    step(d, 1'b0, 1'b0, 1'b0, 1'b1);
    step(NK, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: every cycle the DUT presents a fresh output vector.
  always @(posedge clock) begin
    out_t e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{key_ms_hr, key_ls_hr, key_ms_min, key_ls_min,
            show_new_time, show_a, load_new_a, load_new_c, key_error};
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL outputs @%0t: got key=%h%h:%h%h snt=%b sa=%b la=%b lc=%b err=%b, expected key=%h%h:%h%h snt=%b sa=%b la=%b lc=%b err=%b",
                 $time, a.ms_hr, a.ls_hr, a.ms_min, a.ls_min, a.snt, a.sa, a.la, a.lc, a.err,
                 e.ms_hr, e.ls_hr, e.ms_min, e.ls_min, e.snt, e.sa, e.la, e.lc, e.err);
      end
    end
  end

  initial begin
    key = 4'(NK); alarm_button = 1'b0; time_button = 1'b0; one_second = 1'b0; reset = 1'b0;
    step(NK, 1'b0, 1'b0, 1'b0, 1'b0);
    step(NK, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // 1: 12:30 committed as time
    tap(1); tap(2); tap(3); tap(0);
    step(NK, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(4);

    // 2: 07:45 committed as alarm with a long button hold
    tap(0); tap(7); tap(4); tap(5);
    for (int i = 0; i < 5; i++) step(NK, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);
    for (int i = 0; i < 3; i++) step(NK, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);

    // 3: 25:00 rejected
    tap(2); tap(5); tap(0); tap(0);
    step(NK, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(4);

    // 4: timeout, then a press on the penultimate tick restarts it
    tap(3);
    for (int i = 0; i < TIMEOUT + 2; i++) begin
      step(NK, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(2);
    end
    tap(4);
    for (int i = 0; i < TIMEOUT - 2; i++) begin
      step(NK, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(1);
    end
    step(6, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < TIMEOUT + 2; i++) begin
      step(NK, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(1);
    end

    // 5: held key, ignored codes, five-digit overflow
    for (int i = 0; i < 20; i++) step(9, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    for (int i = 0; i < 3; i++) step(12, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    for (int d = 1; d <= 5; d++) tap(d);
    step(NK, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(3);

    // 6: reset mid-entry with time_button high
    tap(1); tap(1);
    step(NK, 1'b0, 1'b1, 1'b0, 1'b0);
    step(NK, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(NK, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(3);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      int   k;
      logic ab, tb, tk, rs;
      k  = ($urandom_range(0, 9) < 6) ? NK : int'($urandom_range(0, 15));
      ab = ($urandom_range(0, 19) == 0);
      tb = ($urandom_range(0, 19) == 0);
      tk = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 499) != 0);
      step(k, ab, tb, tk, rs);
    end
    idle(2);
    @(posedge clock);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
